// File: rtl/stage_pkg.sv
// Shared stage encodings, state width and role constants for the game stage controller.
package stage_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_MENU      = 3'd0,
    ST_LINK      = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_GAME      = 3'd3,
    ST_OVER      = 3'd4
  } stage_e;

  localparam logic ROLE_MASTER = 1'b0;
  localparam logic ROLE_SLAVE  = 1'b1;

endpackage

// File: rtl/stage_ctrl_click_pulse.sv
// click_pulse: turns a button level into a registered one-cycle pulse on each 0->1 edge.
module click_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q, level_d;
  logic pulse_q, pulse_d;

  always_comb begin
    level_d = level;
    pulse_d = level & ~level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/stage_ctrl.sv
// Stage controller: MENU/LINK/COUNTDOWN/GAME/OVER sequencing with peer link handshake.
// Optional LINK timeout is built when STAGE_CTRL_TIMEOUT_EN is defined.
module stage_ctrl
  import stage_pkg::*;
#(
  parameter int NUM_PEERS        = 1,
  parameter int COUNTDOWN_CYCLES = 100000000,
  parameter int TIMEOUT_CYCLES   = 500000000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  mouse_left,
  input  logic                                  on_start_btn,
  input  logic                                  on_connect_btn,
  input  logic                                  on_return_btn,
  input  logic                                  game_finish,
  input  logic [NUM_PEERS-1:0]                  rx_connect,
  input  logic [NUM_PEERS-1:0]                  rx_start,
  input  logic [NUM_PEERS-1:0]                  rx_finish,
  output logic                                  tx_connect,
  output logic                                  tx_start,
  output logic                                  tx_finish,
  output logic [STATE_W-1:0]                    state,
  output logic                                  role,
  output logic [NUM_PEERS-1:0]                  linked,
  output logic                                  game_init,
  output logic                                  timeout,
  output logic [$clog2(COUNTDOWN_CYCLES+1)-1:0] count_left
);

  localparam int CW = $clog2(COUNTDOWN_CYCLES+1);
  localparam logic [CW-1:0] COUNT_LOAD = CW'(COUNTDOWN_CYCLES - 1);

  if (NUM_PEERS < 1 || NUM_PEERS > 4 || COUNTDOWN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("stage_ctrl: parameter out of range");
  end

  logic click;

  click_pulse u_click (
    .clk   (clk),
    .reset (reset),
    .level (mouse_left),
    .pulse (click)
  );

  stage_e               state_q, state_d;
  logic                 role_q, role_d;
  logic [NUM_PEERS-1:0] linked_q, linked_d;
  logic                 tx_connect_q, tx_connect_d;
  logic                 tx_start_q, tx_start_d;
  logic                 tx_finish_q, tx_finish_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 timeout_q, timeout_d;
  logic                 link_expired;

`ifdef STAGE_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;

  // Timer sits at zero outside LINK so every LINK entry starts a fresh dwell.
  always_comb begin
    timer_d = '0;
    if (state_q == ST_LINK && state_d == ST_LINK) timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign link_expired = (timer_q == TIMER_LAST);
`else
  assign link_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    role_d       = role_q;
    linked_d     = linked_q;
    tx_connect_d = tx_connect_q;
    tx_start_d   = 1'b0;
    tx_finish_d  = tx_finish_q;
    count_d      = '0;
    timeout_d    = 1'b0;

    case (state_q)
      ST_MENU: begin
        linked_d     = '0;
        tx_connect_d = 1'b0;
        tx_finish_d  = 1'b0;
        role_d       = ROLE_MASTER;
        if (click && on_connect_btn) begin
          state_d      = ST_LINK;
          role_d       = |rx_connect ? ROLE_SLAVE : ROLE_MASTER;
          tx_connect_d = 1'b1;
        end else if (click && on_start_btn) begin
          state_d = ST_COUNTDOWN;
          count_d = COUNT_LOAD;
        end
      end

      ST_LINK: begin
        linked_d = linked_q | rx_connect;
        if (click && on_return_btn) begin
          state_d      = ST_MENU;
          linked_d     = '0;
          role_d       = ROLE_MASTER;
          tx_connect_d = 1'b0;
        end else if (role_q == ROLE_MASTER && click && on_start_btn && (&linked_q)) begin
          state_d    = ST_COUNTDOWN;
          count_d    = COUNT_LOAD;
          tx_start_d = 1'b1;
        end else if (role_q == ROLE_SLAVE && |(rx_start & linked_q)) begin
          state_d = ST_COUNTDOWN;
          count_d = COUNT_LOAD;
        end else if (link_expired) begin
          state_d      = ST_MENU;
          linked_d     = '0;
          role_d       = ROLE_MASTER;
          tx_connect_d = 1'b0;
          timeout_d    = 1'b1;
        end
      end

      ST_COUNTDOWN: begin
        if (count_q == '0) state_d = ST_GAME;
        else               count_d = count_q - 1'b1;
      end

      ST_GAME: begin
        if (game_finish || |(rx_finish & linked_q)) begin
          state_d     = ST_OVER;
          tx_finish_d = tx_finish_q | game_finish;
        end
      end

      ST_OVER: begin
        if (click && on_return_btn) begin
          state_d      = ST_MENU;
          linked_d     = '0;
          role_d       = ROLE_MASTER;
          tx_connect_d = 1'b0;
          tx_finish_d  = 1'b0;
        end
      end

      default: begin
        state_d      = ST_MENU;
        linked_d     = '0;
        role_d       = ROLE_MASTER;
        tx_connect_d = 1'b0;
        tx_finish_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_MENU;
      role_q       <= ROLE_MASTER;
      linked_q     <= '0;
      tx_connect_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_finish_q  <= 1'b0;
      count_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      role_q       <= role_d;
      linked_q     <= linked_d;
      tx_connect_q <= tx_connect_d;
      tx_start_q   <= tx_start_d;
      tx_finish_q  <= tx_finish_d;
      count_q      <= count_d;
      timeout_q    <= timeout_d;
    end
  end

  assign state      = state_q;
  assign role       = role_q;
  assign linked     = linked_q;
  assign tx_connect = tx_connect_q;
  assign tx_start   = tx_start_q;
  assign tx_finish  = tx_finish_q;
  assign count_left = count_q;
  assign timeout    = timeout_q;
  assign game_init  = (state_q != ST_GAME);

endmodule

// File: tb/tb_stage_ctrl.sv
// Directed bench for stage_ctrl: solo, master, slave, button priority, LINK dwell and async reset.
module tb_stage_ctrl;

  localparam int NP = 2;
  localparam int CD = 8;
  localparam int TO = 16;
  localparam int CW = $clog2(CD+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mouse_left = 1'b0;
  logic          on_start_btn = 1'b0, on_connect_btn = 1'b0, on_return_btn = 1'b0;
  logic          game_finish = 1'b0;
  logic [NP-1:0] rx_connect = '0, rx_start = '0, rx_finish = '0;
  logic          tx_connect, tx_start, tx_finish, role, game_init, timeout;
  logic [2:0]    state;
  logic [NP-1:0] linked;
  logic [CW-1:0] count_left;

  int tests = 0;
  int fails = 0;

  stage_ctrl #(.NUM_PEERS(NP), .COUNTDOWN_CYCLES(CD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .mouse_left(mouse_left),
    .on_start_btn(on_start_btn), .on_connect_btn(on_connect_btn), .on_return_btn(on_return_btn),
    .game_finish(game_finish), .rx_connect(rx_connect), .rx_start(rx_start), .rx_finish(rx_finish),
    .tx_connect(tx_connect), .tx_start(tx_start), .tx_finish(tx_finish), .state(state),
    .role(role), .linked(linked), .game_init(game_init), .timeout(timeout), .count_left(count_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press with the given buttons hovered; returns just after the edge that acts on the click.
  task automatic do_click(input logic st, input logic cn, input logic rt);
    on_start_btn = st; on_connect_btn = cn; on_return_btn = rt;
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    tick();
    on_start_btn = 1'b0; on_connect_btn = 1'b0; on_return_btn = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_state", 32'(state), 0);
    check("rst_game_init", 32'(game_init), 1);
    check("rst_outputs", {tx_connect, tx_start, tx_finish, role, timeout, linked, count_left}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Solo path
    do_click(1, 0, 0);
    check("solo_countdown", 32'(state), 2);
    check("solo_count_load", 32'(count_left), CD - 1);
    check("solo_tx_connect", 32'(tx_connect), 0);
    tick(CD - 1);
    check("solo_count_zero", {29'd0, state}, 2);
    check("solo_count_left0", 32'(count_left), 0);
    tick();
    check("solo_game", 32'(state), 3);
    check("solo_game_init0", 32'(game_init), 0);
    game_finish = 1'b1;
    tick();
    game_finish = 1'b0;
    check("solo_over", 32'(state), 4);
    check("solo_tx_finish", 32'(tx_finish), 1);
    check("solo_over_init", 32'(game_init), 1);
    do_click(0, 0, 1);
    check("solo_menu", 32'(state), 0);
    check("solo_fin_clear", 32'(tx_finish), 0);

    // Master with two peers
    do_click(0, 1, 0);
    check("mst_link", 32'(state), 1);
    check("mst_role", 32'(role), 0);
    check("mst_tx_connect", 32'(tx_connect), 1);
    rx_connect = 2'b01;
    tick();
    check("mst_linked01", 32'(linked), 2'b01);
    do_click(1, 0, 0);
    check("mst_start_ignored", 32'(state), 1);
    check("mst_no_tx_start", 32'(tx_start), 0);
    rx_connect = 2'b11;
    tick();
    check("mst_linked11", 32'(linked), 2'b11);
    do_click(1, 0, 0);
    check("mst_countdown", 32'(state), 2);
    check("mst_tx_start_hi", 32'(tx_start), 1);
    tick();
    check("mst_tx_start_lo", 32'(tx_start), 0);
    check("mst_count6", 32'(count_left), CD - 2);
    tick(3);
    check("mst_count3", 32'(count_left), 3);

    // Asynchronous reset mid-countdown, away from any clock edge
    #2;
    reset = 1'b1;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_count", 32'(count_left), 0);
    check("arst_game_init", 32'(game_init), 1);
    check("arst_link", {tx_connect, linked}, 0);
    rx_connect = '0;
    tick();
    reset = 1'b0;
    tick();

    // Slave
    rx_connect = 2'b01;
    do_click(0, 1, 0);
    check("slv_link", 32'(state), 1);
    check("slv_role", 32'(role), 1);
    tick();
    check("slv_linked", 32'(linked), 2'b01);
    rx_start = 2'b01;
    tick();
    rx_start = '0;
    check("slv_countdown", 32'(state), 2);
    check("slv_no_tx_start", 32'(tx_start), 0);
    tick(CD);
    check("slv_game", 32'(state), 3);
    rx_finish = 2'b01;
    tick();
    rx_finish = '0;
    check("slv_over", 32'(state), 4);
    check("slv_tx_finish0", 32'(tx_finish), 0);
    check("slv_tx_connect", 32'(tx_connect), 1);
    do_click(0, 0, 1);
    check("slv_menu", {29'd0, state}, 0);
    check("slv_cleared", {role, tx_connect, linked}, 0);

    // Both menu buttons: connect wins; in LINK return beats start
    rx_connect = '0;
    do_click(1, 1, 0);
    check("both_connect_wins", 32'(state), 1);
    rx_connect = 2'b11;
    tick();
    do_click(1, 0, 1);
    check("return_beats_start", 32'(state), 0);
    check("return_clr_linked", 32'(linked), 0);
    rx_connect = '0;

    // LINK dwell without peers
    do_click(0, 1, 0);
    tick(TO - 1);
    check("dwell_still_link", 32'(state), 1);
    check("dwell_no_timeout", 32'(timeout), 0);
    tick();
`ifdef STAGE_CTRL_TIMEOUT_EN
    check("to_menu", 32'(state), 0);
    check("to_pulse", 32'(timeout), 1);
    check("to_linked", 32'(linked), 0);
    tick();
    check("to_pulse_end", 32'(timeout), 0);
`else
    check("noto_link", 32'(state), 1);
    check("noto_timeout", 32'(timeout), 0);
    tick(TO);
    check("noto_link_long", 32'(state), 1);
    do_click(0, 0, 1);
    check("noto_return", 32'(state), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage_ctrl.md
STAGE_CTRL -- requirements
Module: stage_ctrl

Interface
REQ-001 SHALL have parameter NUM_PEERS, 1, number of link peers (1..4).
REQ-002 SHALL have parameter COUNTDOWN_CYCLES, 100000000, length of pre-game countdown in clk cycles (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 500000000, maximum LINK dwell in clk cycles (>=1).
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port mouse_left  input  1  left button level, 1 = pressed.
REQ-007 SHALL have ports on_start_btn, on_connect_btn, on_return_btn  input  1 each  cursor over the named button.
REQ-008 SHALL have port game_finish  input  1  local board solved.
REQ-009 SHALL have ports rx_connect, rx_start, rx_finish  input  NUM_PEERS each  per-peer link levels.
REQ-010 SHALL have ports tx_connect, tx_start, tx_finish  output  1 each  link levels to peers.
REQ-011 SHALL have port state  output  3  current stage encoding.
REQ-012 SHALL have port role  output  1  0 = master, 1 = slave.
REQ-013 SHALL have port linked  output  NUM_PEERS  sticky per-peer connect flags.
REQ-014 SHALL have ports game_init, timeout  output  1 each  board clear request; one-cycle LINK timeout pulse.
REQ-015 SHALL have port count_left  output  $clog2(COUNTDOWN_CYCLES+1)  remaining countdown cycles.

Function
REQ-016 SHALL derive click as a one-cycle pulse, registered, one cycle after a 0->1 edge of mouse_left.
REQ-017 SHALL implement states MENU=0, LINK=1, COUNTDOWN=2, GAME=3, OVER=4; codes 5..7 SHALL go to MENU next cycle.
REQ-018 MENU: click&on_connect_btn SHALL enter LINK and latch role = |rx_connect in that cycle; click&on_start_btn (no connect) SHALL enter COUNTDOWN solo with role=0.
REQ-019 MENU: if both buttons clicked in the same cycle, connect SHALL win.
REQ-020 LINK: tx_connect SHALL be 1; linked[i] SHALL set when rx_connect[i]=1 and stay set until MENU is re-entered.
REQ-021 LINK master: click&on_start_btn&(&linked) SHALL enter COUNTDOWN and pulse tx_start high for exactly one cycle; start click without all linked SHALL be ignored.
REQ-022 LINK slave: any rx_start[i] with linked[i]=1 SHALL enter COUNTDOWN next cycle; tx_start stays 0.
REQ-023 LINK: click&on_return_btn SHALL return to MENU, clearing linked and role, and SHALL take priority over start.
REQ-024 COUNTDOWN: count_left SHALL load COUNTDOWN_CYCLES-1 on entry, decrement each cycle, and at 0 transition to GAME next cycle; count_left SHALL be 0 outside COUNTDOWN.
REQ-025 GAME: game_finish or |(rx_finish & linked) SHALL enter OVER next cycle; local game_finish SHALL also set tx_finish, held until MENU.
REQ-026 GAME: simultaneous local and remote finish SHALL enter OVER once and set tx_finish.
REQ-027 OVER: click&on_return_btn SHALL enter MENU, clearing linked, role, tx_connect, tx_finish.
REQ-028 game_init SHALL be 0 in GAME and 1 in all other states, combinationally from state.
REQ-029 tx_connect SHALL stay 1 through COUNTDOWN, GAME, OVER when entered via LINK; 0 on solo path.

Reset
REQ-030 On reset, state SHALL be MENU and all outputs except game_init SHALL be 0; game_init SHALL be 1.
REQ-031 Reset asserted in any state mid-operation SHALL abort immediately, including an in-flight tx_start pulse and the countdown.

Configuration
REQ-032 Macro STAGE_CTRL_TIMEOUT_EN defined: a LINK timer SHALL count from entry and, if LINK is not left by TIMEOUT_CYCLES cycles, return to MENU with one-cycle timeout=1 and linked cleared.
REQ-033 Macro undefined: LINK SHALL wait indefinitely, no timer SHALL be built, timeout SHALL be tied 0.

Structure
REQ-034 State codes, state width and role constants SHALL live in package stage_pkg.
REQ-035 Click edge detection SHALL be sub-module click_pulse (clk, reset, level in, pulse out).

Verification
REQ-036 Solo: MENU, click on_start_btn -> COUNTDOWN one cycle after click, GAME after COUNTDOWN_CYCLES (test 8), game_finish -> OVER, tx_finish=1.
REQ-037 Master, NUM_PEERS=2: connect click, rx_connect=01, start click ignored; rx_connect=11, start click -> tx_start one-cycle pulse, COUNTDOWN.
REQ-038 Slave: rx_connect=1 at connect click -> role=1; rx_start=1 -> COUNTDOWN; rx_finish=1 in GAME -> OVER, tx_finish=0.
REQ-039 STAGE_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16: no peer -> MENU at cycle 16, timeout pulse once, linked=0.
REQ-040 Reset asserted mid-COUNTDOWN (count_left=3) -> state=0, count_left=0, game_init=1 without waiting for clk.
